pipeline_sequencer: RTL and testbench

Moore-style control sequencer that drives the CPU's per-stage strobes (`doReset`, `doFetch`, `doDecode`, `doSetIP`, `doNext`) and supplies the adjust/target values for the instruction pointer. It sits beside the instruction pointer inside the CPU top level. It steps each instruction through fetch → decode → advance, handshaking with instruction memory and the decoder. It raises a sticky fault on memory timeout or illegal zero-length decode.

---
 rtl/pipeline_sequencer_pkg.sv | 29 ++
 rtl/pipeline_sequencer_if.sv | 40 ++++
 rtl/pipeline_sequencer_stall_timer.sv | 40 ++++
 rtl/pipeline_sequencer.sv | 135 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_pkg
// Shared definitions for the pipeline sequencer:
//   - GR_SIZE     : general-register / PC width
//   - STATE_W     : width of the debug state output
//   - state_t     : sequencer state encodings (visible on the debug port)
//   - cnt_w()     : counter width needed to hold values 0..n
// -----------------------------------------------------------------------------
package pipeline_sequencer_pkg;

    localparam int GR_SIZE = 32;
    localparam int STATE_W = 3;
    localparam int LEN_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_ADVANCE = 3'd3,
        S_HALT    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    // Bits needed to represent 0..n (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_if
// Bundles the sequencer's memory/decoder handshake and the per-stage strobes.
//   master : the sequencer (drives mem_req, strobes, adj_pc, set_pc, fault, state)
//   slave  : the CPU side (drives mem_ack, decoder results, halt)
// -----------------------------------------------------------------------------
interface pipeline_sequencer_if
    import pipeline_sequencer_pkg::*;
#(
    parameter int GR_W = GR_SIZE
);
    logic                mem_req;
    logic                mem_ack;
    logic                dec_valid;
    logic [LEN_W-1:0]    instr_len;
    logic                branch_taken;
    logic [GR_W-1:0]     branch_target;
    logic                halt;
    logic                doReset;
    logic                doFetch;
    logic                doDecode;
    logic                doSetIP;
    logic                doNext;
    logic [GR_W-1:0]     adj_pc;
    logic [GR_W-1:0]     set_pc;
    logic                fault;
    logic [STATE_W-1:0]  state;

    modport master (
        output mem_req, doReset, doFetch, doDecode, doSetIP, doNext,
               adj_pc, set_pc, fault, state,
        input  mem_ack, dec_valid, instr_len, branch_taken, branch_target, halt
    );

    modport slave (
        input  mem_req, doReset, doFetch, doDecode, doSetIP, doNext,
               adj_pc, set_pc, fault, state,
        output mem_ack, dec_valid, instr_len, branch_taken, branch_target, halt
    );
endinterface

// File: rtl/pipeline_sequencer_stall_timer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_stall_timer
// Loadable up/down counter with a terminal-count compare.
// Ports:
//   clk          : clock
//   i_load       : load i_load_value (has priority over counting)
//   i_load_value : value loaded by i_load
//   i_en         : count enable
//   i_up         : 1 = increment, 0 = decrement
//   i_tc_value   : terminal-count compare value
//   o_count      : current count
//   o_tc         : count equals i_tc_value
// -----------------------------------------------------------------------------
module pipeline_sequencer_stall_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_tc_value,
    output logic [W-1:0] o_count,
    output logic         o_tc
);
    logic [W-1:0] r_count;

    // The owner drives i_load from its synchronous reset, so no separate
    // reset input is needed here.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en) begin
            r_count <= i_up ? (r_count + 1'b1) : (r_count - 1'b1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tc_value);
endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Moore control sequencer stepping each instruction through
// FETCH -> DECODE -> ADVANCE, with a reset-hold phase, a fetch timeout and a
// sticky fault.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : pipeline_sequencer_if.master (handshake, strobes, PC values,
//           fault, debug state)
// -----------------------------------------------------------------------------
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int GR_W       = GR_SIZE,
    parameter int RESET_HOLD = 2,
    parameter int MAX_WAIT   = 15
) (
    input  logic clk,
    input  logic reset,
    pipeline_sequencer_if.master bus
);
    localparam int HOLD_W = cnt_w(RESET_HOLD);
    localparam int WAIT_W = cnt_w(MAX_WAIT);

    state_t          r_state;
    logic [GR_W-1:0] r_adj_pc;
    logic [GR_W-1:0] r_set_pc;
    logic            r_fault;
    logic            r_branch;

    logic              w_hold_tc;
    logic [HOLD_W-1:0] w_hold_count;
    logic              w_wait_tc;
    logic [WAIT_W-1:0] w_wait_count;
    logic              w_in_reset;
    logic              w_in_fetch;

    assign w_in_reset = (r_state == S_RESET);
    assign w_in_fetch = (r_state == S_FETCH);

    // Reset-hold countdown: loaded during reset, counts down to zero while
    // S_RESET is held; stops at zero so it cannot wrap.
    pipeline_sequencer_stall_timer #(.W(HOLD_W)) u_hold_timer (
        .clk          (clk),
        .i_load       (reset),
        .i_load_value (HOLD_W'(RESET_HOLD - 1)),
        .i_en         (w_in_reset && !w_hold_tc),
        .i_up         (1'b0),
        .i_tc_value   ('0),
        .o_count      (w_hold_count),
        .o_tc         (w_hold_tc)
    );

    // Fetch-wait count-up: counts fetch cycles without ack. Terminal count is
    // MAX_WAIT-1 because the cycle in which the counter holds that value is
    // itself the MAX_WAIT-th fetch cycle.
    pipeline_sequencer_stall_timer #(.W(WAIT_W)) u_wait_timer (
        .clk          (clk),
        .i_load       (reset || (w_in_fetch && bus.mem_ack)),
        .i_load_value ('0),
        .i_en         (w_in_fetch && !bus.mem_ack),
        .i_up         (1'b1),
        .i_tc_value   (WAIT_W'(MAX_WAIT - 1)),
        .o_count      (w_wait_count),
        .o_tc         (w_wait_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RESET;
            r_adj_pc <= '0;
            r_set_pc <= '0;
            r_fault  <= 1'b0;
            r_branch <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (w_hold_tc) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // An ack arriving on the timeout cycle still wins.
                    if (bus.mem_ack) begin
                        r_state <= S_DECODE;
                    end else if (w_wait_tc) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (bus.dec_valid) begin
                        if (bus.branch_taken) begin
                            r_set_pc <= bus.branch_target;
                            r_branch <= 1'b1;
                            r_state  <= S_ADVANCE;
                        end else if (bus.instr_len != '0) begin
                            r_adj_pc <= GR_W'(bus.instr_len);
                            r_branch <= 1'b0;
                            r_state  <= S_ADVANCE;
                        end else begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_ADVANCE: begin
                    r_state <= bus.halt ? S_HALT : S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the registered state, so they are mutually
    // exclusive by construction.
    assign bus.doReset  = w_in_reset;
    assign bus.doFetch  = w_in_fetch;
    assign bus.mem_req  = w_in_fetch;
    assign bus.doDecode = (r_state == S_DECODE);
    assign bus.doSetIP  = (r_state == S_ADVANCE) &&  r_branch;
    assign bus.doNext   = (r_state == S_ADVANCE) && !r_branch;
    assign bus.adj_pc   = r_adj_pc;
    assign bus.set_pc   = r_set_pc;
    assign bus.fault    = r_fault;
    assign bus.state    = r_state;

    // Counts are only consumed through their terminal flags.
    logic w_unused;
    assign w_unused = ^{w_hold_count, w_wait_count};
endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    localparam int GR_W = 32;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fail;

    pipeline_sequencer_if #(.GR_W(GR_W)) bus ();

    pipeline_sequencer #(
        .GR_W       (GR_W),
        .RESET_HOLD (2),
        .MAX_WAIT   (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        check("strobe_excl",
              {31'b0, ($countones({bus.doReset, bus.doFetch, bus.doDecode,
                                   bus.doSetIP, bus.doNext}) > 1)}, 32'd0);
    endtask

    task automatic check_strobes(input string tag, input logic [5:0] exp);
        check(tag, {26'b0, bus.doReset, bus.doFetch, bus.doDecode,
                    bus.doSetIP, bus.doNext, bus.mem_req}, {26'b0, exp});
    endtask

    // reset high one cycle, then release and wait RESET_HOLD cycles to FETCH
    task automatic reset_to_fetch(input string tag);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check({tag, "_fetch"}, {29'b0, bus.state}, 32'd1);
    endtask

    // One instruction from FETCH; leaves DUT in ADVANCE
    task automatic fetch_decode(input logic br, input logic [31:0] tgt, input logic [3:0] len);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        bus.dec_valid = 1'b1;
        bus.branch_taken = br;
        bus.branch_target = tgt;
        bus.instr_len = len;
        step();
        bus.dec_valid = 1'b0;
        bus.branch_taken = 1'b0;
        bus.instr_len = 4'd0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        bus.dec_valid = 1'b0;
        bus.instr_len = 4'd0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'd0;
        bus.halt = 1'b0;

        // ---- reset: held 3 cycles ----
        step(); step(); step();
        check("rst_state", {29'b0, bus.state}, 32'd0);
        check("rst_fault", {31'b0, bus.fault}, 32'd0);
        check("rst_adj", bus.adj_pc, 32'd0);
        check("rst_set", bus.set_pc, 32'd0);
        reset = 1'b0;
        #1;
        check_strobes("rel_c1", 6'b100000);
        step();
        check_strobes("rel_c2", 6'b100000);
        step();
        check_strobes("rel_c3_fetch", 6'b010001);
        $display("reset release: doReset 2 cycles then doFetch");

        // ---- straight-line: 3 instructions, len 4 ----
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
            check_strobes("sl_decode", 6'b001000);
            bus.dec_valid = 1'b1;
            bus.instr_len = 4'd4;
            step();
            bus.dec_valid = 1'b0;
            bus.instr_len = 4'd0;
            check_strobes("sl_next", 6'b000010);
            check("sl_adj", bus.adj_pc, 32'd4);
            step();
            check_strobes("sl_fetch", 6'b010001);
            $display("straight-line instr %0d: adj_pc=%0d", i, bus.adj_pc);
        end

        // ---- branch with instr_len 0 ----
        fetch_decode(1'b1, 32'h100, 4'd0);
        check_strobes("br_setip", 6'b000100);
        check("br_set", bus.set_pc, 32'h100);
        check("br_adj_hold", bus.adj_pc, 32'd4);
        check("br_fault", {31'b0, bus.fault}, 32'd0);
        step();
        check("br_back_fetch", {29'b0, bus.state}, 32'd1);
        $display("branch: set_pc=0x%0h", bus.set_pc);

        // ---- ack on the 15th fetch cycle ----
        for (int i = 0; i < 14; i++) step();
        check("ack15_pre", {29'b0, bus.state}, 32'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("ack15_state", {29'b0, bus.state}, 32'd2);
        check("ack15_fault", {31'b0, bus.fault}, 32'd0);
        $display("late ack on fetch cycle 15: state=%0d", bus.state);

        // ---- illegal zero length ----
        bus.dec_valid = 1'b1;
        bus.instr_len = 4'd0;
        bus.branch_taken = 1'b0;
        step();
        bus.dec_valid = 1'b0;
        check("ill_state", {29'b0, bus.state}, 32'd5);
        check("ill_fault", {31'b0, bus.fault}, 32'd1);
        check_strobes("ill_strobes", 6'b000000);
        step();
        check("ill_sticky", {29'b0, bus.state}, 32'd5);
        $display("illegal length: state=%0d fault=%0d", bus.state, bus.fault);

        // ---- timeout ----
        reset_to_fetch("to");
        check("to_fault_clr", {31'b0, bus.fault}, 32'd0);
        for (int i = 0; i < 14; i++) step();
        check("to_c15_state", {29'b0, bus.state}, 32'd1);
        step();
        check("to_state", {29'b0, bus.state}, 32'd5);
        check("to_fault", {31'b0, bus.fault}, 32'd1);
        check_strobes("to_strobes", 6'b000000);
        $display("timeout: state=%0d fault=%0d", bus.state, bus.fault);

        // ---- halt ----
        reset_to_fetch("ht");
        fetch_decode(1'b0, 32'd0, 4'd8);
        check_strobes("ht_next", 6'b000010);
        check("ht_adj", bus.adj_pc, 32'd8);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("ht_state", {29'b0, bus.state}, 32'd4);
        check_strobes("ht_strobes", 6'b000000);
        step();
        check("ht_terminal", {29'b0, bus.state}, 32'd4);
        $display("halt: state=%0d", bus.state);

        // ---- mid-op reset while in DECODE ----
        reset_to_fetch("mr");
        fetch_decode(1'b0, 32'd0, 4'd8);
        step();
        fetch_decode(1'b1, 32'h200, 4'd3);
        check("mr_set", bus.set_pc, 32'h200);
        check("mr_adj", bus.adj_pc, 32'd8);
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("mr_in_decode", {29'b0, bus.state}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_state", {29'b0, bus.state}, 32'd0);
        check("mr_adj0", bus.adj_pc, 32'd0);
        check("mr_set0", bus.set_pc, 32'd0);
        check("mr_fault0", {31'b0, bus.fault}, 32'd0);
        step();
        step();
        check_strobes("mr_refetch", 6'b010001);
        $display("mid-op reset: state=%0d adj=%0d set=%0d", bus.state, bus.adj_pc, bus.set_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
